ghost_mode_ctrl: RTL

Shared mode sequencer for all ghosts. It owns the global scatter/chase schedule, per-ghost release from the house, the frightened timer with flashing, the eaten-ghost score chain and Pac-Man death detection. It runs on `frame_clk`, one update per video frame, and sits between the game-state logic and the per-ghost movement/targeting blocks. Those blocks consume `mode`/`reverse` and return `in_box`/`home_reached`.

---
 rtl/ghost_mode_ctrl_if.sv | 28 ++
 rtl/ghost_mode_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ghost_mode_ctrl_if.sv
// ghost_mode_ctrl_if: game-state and ghost-block signals of the shared ghost mode sequencer
interface ghost_mode_ctrl_if #(
  parameter int NUM_GHOSTS = 4,
  parameter int DOT_W = 8
);
  logic soft_reset;
  logic start;
  logic [DOT_W-1:0] dots_eaten;
  logic power_pellet;
  logic [NUM_GHOSTS-1:0] collide;
  logic [NUM_GHOSTS-1:0] in_box;
  logic [NUM_GHOSTS-1:0] home_reached;
  logic [3*NUM_GHOSTS-1:0] mode;
  logic [NUM_GHOSTS-1:0] reverse;
  logic [NUM_GHOSTS-1:0] flash;
  logic [1:0] global_phase;
  logic pacman_dead;
  logic [11:0] ghost_points;
  logic points_valid;
  modport master (
    output soft_reset, start, dots_eaten, power_pellet, collide, in_box, home_reached,
    input mode, reverse, flash, global_phase, pacman_dead, ghost_points, points_valid
  );
  modport slave (
    input soft_reset, start, dots_eaten, power_pellet, collide, in_box, home_reached,
    output mode, reverse, flash, global_phase, pacman_dead, ghost_points, points_valid
  );
endinterface

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: shared scatter/chase schedule, release, fright/flash, score chain and death detection
module ghost_mode_ctrl #(
  parameter int NUM_GHOSTS = 4,
  parameter int DOT_W = 8,
  parameter logic [NUM_GHOSTS*DOT_W-1:0] RELEASE_DOTS = {8'd80, 8'd30, 8'd0, 8'd0},
  parameter int TW = 12,
  parameter int SCATTER1_FR = 420,
  parameter int SCATTER2_FR = 300,
  parameter int CHASE_FR = 1200,
  parameter int FRIGHT_FR = 600,
  parameter int FLASH_FR = 180,
  parameter int FLASH_HALF = 10
) (
  input logic frame_clk,
  input logic Reset,
  ghost_mode_ctrl_if.slave bus
);
  localparam int N = NUM_GHOSTS;
  localparam logic [TW-1:0] S1_END = TW'(SCATTER1_FR - 1);
  localparam logic [TW-1:0] S2_END = TW'(SCATTER2_FR - 1);
  localparam logic [TW-1:0] CH_END = TW'(CHASE_FR - 1);
  localparam logic [TW-1:0] FR_LD = TW'(FRIGHT_FR);
  localparam logic [TW-1:0] FL_LIM = TW'(FLASH_FR);
  localparam logic [TW-1:0] FL_PRE = TW'(FLASH_FR + 1);
  localparam logic [TW-1:0] FH_END = TW'(FLASH_HALF - 1);
  typedef enum logic [1:0] {P_IDLE = 2'd0, P_SCATTER = 2'd1, P_CHASE = 2'd2} phase_t;
  typedef enum logic [1:0] {G_WAIT, G_ACTIVE, G_FRIGHT, G_DEAD} gst_t;
  phase_t phase, phase_n;
  gst_t gs [N];
  gst_t gs_n [N];
  logic [1:0] rnd, rnd_n, chain, chain_n;
  logic started, started_n, dead, dead_n, fph, fph_n, pv, pv_n;
  logic [TW-1:0] ptmr, ptmr_n, fcnt, fcnt_n, ftmr, ftmr_n, dur;
  logic [N-1:0] rev, rev_n, act, fri, kill, elig, eat;
  logic [11:0] pts, pts_n;
  logic frz, run, sw, expire;
  // state register; either reset source returns everything to its idle value
  always_ff @(posedge frame_clk) begin
    if (Reset || bus.soft_reset) begin
      phase <= P_IDLE;
      rnd <= '0;
      started <= 1'b0;
      ptmr <= '0;
      fcnt <= '0;
      ftmr <= '0;
      fph <= 1'b0;
      chain <= '0;
      rev <= '0;
      dead <= 1'b0;
      pts <= '0;
      pv <= 1'b0;
      for (int i = 0; i < N; i++) gs[i] <= G_WAIT;
    end else begin
      phase <= phase_n;
      rnd <= rnd_n;
      started <= started_n;
      ptmr <= ptmr_n;
      fcnt <= fcnt_n;
      ftmr <= ftmr_n;
      fph <= fph_n;
      chain <= chain_n;
      rev <= rev_n;
      dead <= dead_n;
      pts <= pts_n;
      pv <= pv_n;
      for (int i = 0; i < N; i++) gs[i] <= gs_n[i];
    end
  end
  // next-state: a kill this frame freezes everything at once, so a same-frame pellet is ignored
  always_comb begin
    for (int i = 0; i < N; i++) begin
      act[i] = gs[i] == G_ACTIVE;
      fri[i] = gs[i] == G_FRIGHT;
    end
    kill = bus.collide & act;
    elig = bus.collide & fri;
    eat = elig & (~elig + 1'b1);
    frz = dead || (|kill);
    dur = phase == P_SCATTER ? (rnd < 2'd2 ? S1_END : S2_END) : CH_END;
    run = (phase == P_SCATTER || (phase == P_CHASE && rnd != 2'd3)) && fcnt == '0;
    sw = run && ptmr == dur;
    expire = fcnt == TW'(1) && !bus.power_pellet;
    phase_n = phase;
    rnd_n = rnd;
    started_n = started;
    ptmr_n = ptmr;
    fcnt_n = fcnt;
    ftmr_n = ftmr;
    fph_n = fph;
    chain_n = chain;
    pts_n = pts;
    pv_n = 1'b0;
    rev_n = '0;
    dead_n = frz;
    for (int i = 0; i < N; i++) gs_n[i] = gs[i];
    if (!frz) begin
      started_n = started || bus.start;
      phase_n = phase == P_IDLE ? (bus.start ? P_SCATTER : P_IDLE)
              : sw ? (phase == P_SCATTER ? P_CHASE : P_SCATTER) : phase;
      rnd_n = sw && phase == P_CHASE ? rnd + 1'b1 : rnd;
      ptmr_n = sw ? '0 : run ? ptmr + 1'b1 : ptmr;
      fcnt_n = bus.power_pellet ? FR_LD : fcnt != '0 ? fcnt - 1'b1 : fcnt;
      ftmr_n = bus.power_pellet || fcnt == FL_PRE || ftmr == FH_END ? '0
             : fcnt != '0 && fcnt <= FL_LIM ? ftmr + 1'b1 : ftmr;
      fph_n = bus.power_pellet ? 1'b0 : fcnt == FL_PRE ? 1'b1
            : fcnt != '0 && fcnt <= FL_LIM && ftmr == FH_END ? !fph : fph;
      chain_n = bus.power_pellet ? '0 : (|eat) && chain != 2'd3 ? chain + 1'b1 : chain;
      pv_n = |eat;
      pts_n = |eat ? 12'd200 << chain : pts;
      for (int i = 0; i < N; i++) begin
        rev_n[i] = act[i] && (sw || (bus.power_pellet && !bus.in_box[i]));
        gs_n[i] = gs[i] == G_WAIT ? (started && bus.dots_eaten >= RELEASE_DOTS[i*DOT_W +: DOT_W] ? G_ACTIVE : G_WAIT)
                : gs[i] == G_ACTIVE ? (bus.power_pellet && !bus.in_box[i] ? G_FRIGHT : G_ACTIVE)
                : gs[i] == G_FRIGHT ? (eat[i] ? G_DEAD : expire ? G_ACTIVE : G_FRIGHT)
                : (bus.home_reached[i] ? G_ACTIVE : G_DEAD);
      end
    end
  end
  // per-ghost mode code and white-sprite flag, derived from registered state only
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.mode[3*i +: 3] = gs[i] == G_WAIT ? 3'd0 : gs[i] == G_ACTIVE ? {1'b0, phase}
                         : gs[i] == G_FRIGHT ? 3'd3 : 3'd4;
      bus.flash[i] = fri[i] && fcnt <= FL_LIM && fph;
    end
  end
  assign bus.reverse = rev;
  assign bus.global_phase = phase;
  assign bus.pacman_dead = dead;
  assign bus.ghost_points = pts;
  assign bus.points_valid = pv;
endmodule
